// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel fetch block: pixel widths, the
// RGB565 -> RGB888 expansion, the test-pattern bar colours and the fetch
// FSM state encoding.
package vga_pkg;

    localparam int unsigned RGB565_W = 16;
    localparam int unsigned RGB888_W = 24;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        RUN       = 1'b1
    } fetch_state_t;

    // Bar colours left to right; index 0 is the leftmost bar.
    localparam logic [7:0][RGB888_W-1:0] BAR_RGB = {
        24'h000000,  // 7 black
        24'h0000FF,  // 6 blue
        24'hFF0000,  // 5 red
        24'hFF00FF,  // 4 magenta
        24'h00FF00,  // 3 green
        24'h00FFFF,  // 2 cyan
        24'hFFFF00,  // 1 yellow
        24'hFFFFFF   // 0 white
    };

    // Expand by replicating the top bits of each channel into the low bits.
    function automatic logic [RGB888_W-1:0] rgb565_to_888(input logic [RGB565_W-1:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clocked shift register that carries the timing/control flags alongside
// the framebuffer read, so they arrive together with the read data.
module vga_sync_delay #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    // Shift the flag word one stage per clock; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: converts the rd_in window strobe into linear reads of an
// RD_H x RD_V RGB565 framebuffer and returns delay-matched hs/vs/de with
// 8:8:8 colour. Total latency is MEM_LAT+2 cycles.
// Optional feature: define VGA_PIXEL_FETCH_TESTPAT_EN to add the test_en
// input, which replaces framebuffer reads by eight vertical colour bars.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned RD_H       = 480,
    parameter int unsigned RD_V       = 272,
    parameter int unsigned MEM_LAT    = 2,
    parameter logic        VS_POL     = 1'b1,
    parameter logic [23:0] BORDER_RGB = 24'h000000,
    parameter int unsigned AW         = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic                de_in,
    input  logic                rd_in,
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
    input  logic                test_en,
`endif
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_addr,
    input  logic [RGB565_W-1:0] mem_rdata,
    output logic                hs_out,
    output logic                vs_out,
    output logic                de_out,
    output logic [RGB888_W-1:0] rgb_out,
    output logic                frame_err
);

    localparam int unsigned L     = MEM_LAT + 2;
    localparam int unsigned TOTAL = RD_H * RD_V;
    // One extra bit so the counter can sit at RD_H*RD_V when it equals 2**AW.
    localparam int unsigned CW    = AW + 1;
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

    // Flag word bit positions inside the delay line.
    localparam int unsigned B_HS  = 0;
    localparam int unsigned B_VS  = 1;
    localparam int unsigned B_DE  = 2;
    localparam int unsigned B_RD  = 3;
    localparam int unsigned B_ISS = 4;
    localparam int unsigned B_ACT = 5;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
    localparam int unsigned B_TST = 6;
    localparam int unsigned B_BAR = 7;
    localparam int unsigned FW    = 10;
    localparam int unsigned BAR_W = RD_H / 8;
    localparam int unsigned SW    = $clog2(BAR_W + 1);
`else
    localparam int unsigned FW    = 6;
`endif

    fetch_state_t  state, state_next;
    logic          vs_prev;
    logic [CW-1:0] cnt, cnt_next, cnt_base;
    logic          frame_start, active, has_room, take, overrun, issue, err_next;
    logic          test_mode;
    logic [FW-1:0] flags_in, flags_d;
    logic [RGB888_W-1:0] rgb_next;

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
    logic          rd_prev;
    logic [SW-1:0] sub, sub_base;
    logic [2:0]    bar, bar_base;

    assign test_mode = test_en;
`else
    assign test_mode = 1'b0;
`endif

    // Next-state, counter and read decision for the current input cycle.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        frame_start = (vs_in == VS_POL) && (vs_prev != VS_POL);
        active      = (state == RUN) || frame_start;
        cnt_base    = frame_start ? '0 : cnt;
        has_room    = cnt_base < TOTAL_C;
        take        = active && rd_in && has_room;
        overrun     = active && rd_in && !has_room;
        issue       = take && !test_mode;
        err_next    = frame_err || overrun ||
                      (frame_start && (state == RUN) && (cnt != TOTAL_C));
        if (frame_start) begin
            state_next = RUN;
        end
        if (active) begin
            cnt_next = take ? cnt_base + CW'(1) : cnt_base;
        end
    end

    // FSM state, pixel counter, sticky error and registered read request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC_WAIT;
            vs_prev   <= VS_POL;
            cnt       <= '0;
            frame_err <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_next;
            vs_prev   <= vs_in;
            cnt       <= cnt_next;
            frame_err <= err_next;
            mem_rd_en <= issue;
            if (issue) begin
                mem_addr <= cnt_base[AW-1:0];
            end
        end
    end

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
    // Bar position of the current rd pixel; restarts on each rd_in rising edge.
    always_comb begin
        sub_base = (rd_in && !rd_prev) ? '0 : sub;
        bar_base = (rd_in && !rd_prev) ? '0 : bar;
    end

    // Column counter for the test bars, advancing once per rd pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_prev <= 1'b0;
            sub     <= '0;
            bar     <= '0;
        end else begin
            rd_prev <= rd_in;
            if (rd_in) begin
                if (sub_base == SW'(BAR_W - 1)) begin
                    sub <= '0;
                    bar <= (bar_base == 3'd7) ? 3'd7 : bar_base + 3'd1;
                end else begin
                    sub <= sub_base + SW'(1);
                    bar <= bar_base;
                end
            end
        end
    end
`endif

    // Pack the per-pixel flags that must travel with the read.
    always_comb begin
        flags_in        = '0;
        flags_in[B_HS]  = hs_in;
        flags_in[B_VS]  = vs_in;
        flags_in[B_DE]  = de_in;
        flags_in[B_RD]  = rd_in;
        flags_in[B_ISS] = issue;
        flags_in[B_ACT] = active;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
        flags_in[B_TST]       = test_en;
        flags_in[B_BAR +: 3]  = bar_base;
`endif
    end

    // L-1 stages here; the output register below is stage L, so the flags
    // line up with mem_rdata on the cycle it is valid.
    vga_sync_delay #(
        .W     (FW),
        .DEPTH (L - 1)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (flags_in),
        .dout (flags_d)
    );

    // Output colour selection from the delayed flags.
    always_comb begin
        rgb_next = '0;
        if (flags_d[B_DE] && flags_d[B_ACT]) begin
            rgb_next = BORDER_RGB;
            if (flags_d[B_RD] && flags_d[B_ISS]) begin
                rgb_next = rgb565_to_888(mem_rdata);
            end
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
            if (flags_d[B_TST] && flags_d[B_RD]) begin
                rgb_next = BAR_RGB[flags_d[B_BAR +: 3]];
            end
`endif
        end
    end

    // Final output register for timing and colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_out  <= 1'b0;
            vs_out  <= 1'b0;
            de_out  <= 1'b0;
            rgb_out <= '0;
        end else begin
            hs_out  <= flags_d[B_HS];
            vs_out  <= flags_d[B_VS];
            de_out  <= flags_d[B_DE];
            rgb_out <= rgb_next;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised bench for vga_pixel_fetch on a small 16x4 framebuffer.
// A behavioural model computes, per input cycle, the expected read request,
// sticky error and L-cycle-delayed video outputs; one compare process checks
// the DUT against it on every clock, plus a few literal expectations.
module tb_vga_pixel_fetch;

    localparam int unsigned RD_H    = 16;
    localparam int unsigned RD_V    = 4;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned AW      = 6;
    localparam logic        VS_POL  = 1'b1;
    localparam logic        VS_IDLE = ~VS_POL;
    localparam logic [23:0] BORDER  = 24'h102030;
    localparam int unsigned L       = MEM_LAT + 2;
    localparam int unsigned TOTAL   = RD_H * RD_V;
    localparam int unsigned MAXS    = 8192;

    logic          clk = 1'b0;
    logic          rst, hs_in, vs_in, de_in, rd_in;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          hs_out, vs_out, de_out, frame_err;
    logic [23:0]   rgb_out;
    logic          test_en;

    always #5 clk = ~clk;

    vga_pixel_fetch #(
        .RD_H       (RD_H),
        .RD_V       (RD_V),
        .MEM_LAT    (MEM_LAT),
        .VS_POL     (VS_POL),
        .BORDER_RGB (BORDER),
        .AW         (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .rd_in     (rd_in),
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
        .test_en   (test_en),
`endif
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .de_out    (de_out),
        .rgb_out   (rgb_out),
        .frame_err (frame_err)
    );

    function automatic bit [15:0] mem_word(input int unsigned a);
        return 16'((a * 32'd40503) ^ (a << 7) ^ 32'h5A3C);
    endfunction

    function automatic bit [23:0] expand(input int unsigned w);
        int unsigned r5, g6, b5;
        r5 = (w >> 11) & 31;
        g6 = (w >> 5) & 63;
        b5 = w & 31;
        return 24'((((r5 << 3) | (r5 >> 2)) << 16) |
                   (((g6 << 2) | (g6 >> 4)) << 8) |
                   ((b5 << 3) | (b5 >> 2)));
    endfunction

    function automatic bit [23:0] bar_colour(input int unsigned col);
        int unsigned b;
        b = col / (RD_H / 8);
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Framebuffer: word returned MEM_LAT cycles after a read, junk otherwise.
    logic [AW:0] mpipe [MEM_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= {mem_rd_en, mem_addr};
            for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mem_rdata = mpipe[MEM_LAT-1][AW] ? mem_word(int'(mpipe[MEM_LAT-1][AW-1:0])) : 16'hDEAD;

    // Expected values per input cycle.
    bit          e_hs [MAXS], e_vs [MAXS], e_de [MAXS], e_en [MAXS], e_err [MAXS];
    bit [23:0]   e_rgb [MAXS];
    bit [AW-1:0] e_addr [MAXS];
    bit          f_first [MAXS], f_last [MAXS], f_border [MAXS], f_err1 [MAXS];

    int          nstep = 0, cur_step = 0, last_rst = 0, last_idx = 0;
    bit          started = 0;
    int          errors = 0, checks = 0;

    // Model state.
    bit          m_sync, m_err, m_prev_vs, m_prev_rd, m_test;
    int unsigned m_cnt, m_col;
    bit [AW-1:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int n);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    task automatic drive(input bit h, input bit v, input bit d, input bit r, input bit do_rst);
        bit fs, act, rd_ok;
        int unsigned colnow;
        bit [23:0] px;
        int n;
        @(posedge clk);
        #1;
        n = nstep;
        if (n >= MAXS) begin
            $display("FAIL step_budget step=%0d actual=%0d required<%0d", n, n, MAXS);
            errors++;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "step budget exhausted");
        end
        rst = do_rst; hs_in = h; vs_in = v; de_in = d; rd_in = r;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
        m_test = test_en;
`else
        m_test = 0;
`endif
        if (do_rst) begin
            m_sync = 0; m_err = 0; m_prev_vs = VS_POL; m_prev_rd = 0;
            m_cnt = 0; m_col = 0; m_addr = '0;
            e_hs[n] = 0; e_vs[n] = 0; e_de[n] = 0; e_en[n] = 0;
            e_err[n] = 0; e_rgb[n] = '0; e_addr[n] = '0;
            last_rst = n;
        end else begin
            fs  = (v == VS_POL) && (m_prev_vs != VS_POL);
            act = m_sync || fs;
            if (fs) begin
                if (m_sync && m_cnt != TOTAL) m_err = 1;
                m_cnt  = 0;
                m_sync = 1;
            end
            colnow = (r && !m_prev_rd) ? 0 : m_col;
            if (r) m_col = colnow + 1;
            m_prev_rd = r;
            rd_ok = 0;
            if (act && r) begin
                if (m_cnt < TOTAL) begin
                    if (!m_test) begin
                        rd_ok  = 1;
                        m_addr = AW'(m_cnt);
                    end
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (!d || !act)       px = '0;
            else if (m_test && r) px = bar_colour(colnow);
            else if (rd_ok)       px = expand(mem_word(int'(m_addr)));
            else                  px = BORDER;
            e_hs[n] = h; e_vs[n] = v; e_de[n] = d; e_en[n] = rd_ok;
            e_addr[n] = m_addr; e_err[n] = m_err; e_rgb[n] = px;
            m_prev_vs = v;
        end
        last_idx = n;
        cur_step = n;
        nstep++;
    endtask

    // One compare process: read side one cycle after the input, video L after.
    always @(negedge clk) begin
        int n, k;
        if (started) begin
            n = cur_step;
            k = n - L;
            if (last_rst >= n - 1) begin
                chk("mem_rd_en", 32'(mem_rd_en), 32'd0, n);
                chk("mem_addr",  32'(mem_addr),  32'd0, n);
                chk("frame_err", 32'(frame_err), 32'd0, n);
            end else begin
                chk("mem_rd_en", 32'(mem_rd_en), 32'(e_en[n-1]),   n);
                chk("mem_addr",  32'(mem_addr),  32'(e_addr[n-1]), n);
                chk("frame_err", 32'(frame_err), 32'(e_err[n-1]),  n);
                if (f_first[n-1]) begin
                    chk("first_read_en",   32'(mem_rd_en), 32'd1, n);
                    chk("first_read_addr", 32'(mem_addr),  32'd0, n);
                end
                if (f_last[n-1]) chk("last_read_addr", 32'(mem_addr), 32'd63, n);
                if (f_err1[n-1]) chk("short_frame_err", 32'(frame_err), 32'd1, n);
            end
            if (last_rst >= k) begin
                chk("hs_out",  32'(hs_out),  32'd0, n);
                chk("vs_out",  32'(vs_out),  32'd0, n);
                chk("de_out",  32'(de_out),  32'd0, n);
                chk("rgb_out", 32'(rgb_out), 32'd0, n);
            end else begin
                chk("hs_out",  32'(hs_out),  32'(e_hs[k]),  n);
                chk("vs_out",  32'(vs_out),  32'(e_vs[k]),  n);
                chk("de_out",  32'(de_out),  32'(e_de[k]),  n);
                chk("rgb_out", 32'(rgb_out), 32'(e_rgb[k]), n);
                if (f_border[k]) chk("border_rgb", 32'(rgb_out), 32'h102030, n);
            end
        end
    end

    task automatic reset_cycles(input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) drive(0, VS_IDLE, 0, 0, 1);
    endtask

    task automatic junk(input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++)
            drive(1'($urandom_range(0, 1)), VS_IDLE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    endtask

    // One frame of npix rd pixels; optional rd on the vs edge, error mark,
    // or a reset once abort_at pixels have been sent.
    task automatic frame(input int unsigned npix, input bit fs_rd, input bit mark_err, input int unsigned abort_at);
        int unsigned sent;
        bit first_done;
        sent = 0;
        first_done = 0;
        if (fs_rd) begin
            drive(0, VS_POL, 1, 1, 0);
            if (!m_test) f_first[last_idx] = 1;
            sent = 1;
            first_done = 1;
        end else begin
            drive(0, VS_POL, 0, 0, 0);
        end
        if (mark_err) f_err1[last_idx] = 1;
        drive(0, VS_POL, 0, 0, 0);
        drive(0, VS_IDLE, 0, 0, 0);
        drive(0, VS_IDLE, 0, 0, 0);
        while (sent < npix) begin
            drive(1, VS_IDLE, 0, 0, 0);
            drive(1, VS_IDLE, 0, 0, 0);
            drive(0, VS_IDLE, 1, 0, 0);
            f_border[last_idx] = 1;
            for (int unsigned p = 0; p < RD_H && sent < npix; p++) begin
                if (sent == abort_at) begin
                    reset_cycles(2);
                    return;
                end
                if ($urandom_range(0, 7) == 0) drive(0, VS_IDLE, 1'($urandom_range(0, 1)), 0, 0);
                drive(0, VS_IDLE, 1'($urandom_range(0, 15) != 0), 1, 0);
                if (!first_done && !m_test) f_first[last_idx] = 1;
                first_done = 1;
                if (npix == TOTAL && sent == TOTAL - 1 && !m_test) f_last[last_idx] = 1;
                sent++;
            end
            drive(0, VS_IDLE, 1, 0, 0);
            drive(0, VS_IDLE, 0, 0, 0);
            drive(0, VS_IDLE, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1; hs_in = 0; vs_in = VS_IDLE; de_in = 0; rd_in = 0; test_en = 0;
        reset_cycles(3);
        started = 1;
        junk(30);                              // before first sync: no reads, black
        frame(TOTAL, 0, 0, 9999);              // first frame, not checked for count
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL - 2, 0, 0, 9999);          // short frame
        frame(TOTAL, 0, 1, 9999);              // error flagged at this frame start
        frame(TOTAL, 0, 0, 9999);              // error stays set
        frame(TOTAL, 0, 0, 30);                // reset mid-frame
        junk(20);
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL + 1, 0, 0, 9999);          // overrun pixel
        frame(TOTAL, 1, 0, 9999);              // rd on the frame-start edge
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
        test_en = 1;
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL, 0, 0, 9999);
        test_en = 0;
`endif
        frame(TOTAL, 0, 0, 9999);
        frame(TOTAL, 0, 0, 9999);
        for (int unsigned i = 0; i < L + 3; i++) drive(0, VS_IDLE, 0, 0, 0);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout step=%0d actual=running required=finished", cur_step);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
